// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the set-associative write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REFILL,
    FLUSH
  } state_e;

  function automatic int unsigned off_bits(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_width,
                                           input int unsigned sets,
                                           input int unsigned words_per_line);
    return addr_width - $clog2(sets) - $clog2(words_per_line) - 2;
  endfunction

  // Word-aligned byte address {tag, index, word, 2'b00}; callers truncate to their width.
  function automatic logic [63:0] line_beat_addr(input logic [63:0] tag,
                                                 input logic [63:0] idx,
                                                 input logic [63:0] word,
                                                 input int unsigned off,
                                                 input int unsigned idxw);
    return (tag << (off + idxw + 2)) | (idx << (off + 2)) | (word << 2);
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: per-set valid/dirty/tag plus line data, one read port and one write port.
module dcache_way_array #(
  parameter int unsigned SETS           = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned IDXW           = 4,
  parameter int unsigned WBITS          = 2,
  parameter int unsigned TAGW           = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDXW-1:0]  rd_idx,
  input  logic [WBITS-1:0] rd_word,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TAGW-1:0]  rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [WBITS-1:0] wr_word,
  input  logic [31:0]      wr_data,
  input  logic             set_dirty,
  input  logic             clean_en,
  input  logic             fill_en,
  input  logic [TAGW-1:0]  fill_tag
);

  logic [SETS-1:0] valid_q;
  logic [SETS-1:0] dirty_q;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS][WORDS_PER_LINE];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_word];

  // Storage writes sit in the non-reset branch so a reset mid-burst leaves no line update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_en) begin
        data_q[wr_idx][wr_word] <= wr_data;
        if (set_dirty) dirty_q[wr_idx] <= 1'b1;
      end
      if (clean_en) dirty_q[wr_idx] <= 1'b0;
      if (fill_en) begin
        valid_q[wr_idx] <= 1'b1;
        tag_q[wr_idx]   <= fill_tag;
        dirty_q[wr_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dcache_sa_wb.sv
// Set-associative write-back write-allocate data cache with burst refill/write-back and flush walk.
module dcache_sa_wb
  import dcache_pkg::*;
#(
  parameter int unsigned SETS           = 16,
  parameter int unsigned WAYS           = 2,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           WriteData,
  input  logic                  Flush,
  output logic                  Hit,
  output logic [31:0]           Data,
  output logic                  Busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);

  localparam int unsigned OFF   = off_bits(WORDS_PER_LINE);
  localparam int unsigned IDXW  = idx_bits(SETS);
  localparam int unsigned TAGW  = tag_bits(ADDR_WIDTH, SETS, WORDS_PER_LINE);
  localparam int unsigned WBITS = (OFF == 0) ? 1 : OFF;
  localparam int unsigned VW    = (WAYS == 1) ? 1 : $clog2(WAYS);

  state_e           state_q, state_d;
  logic [WBITS-1:0] beat_q, beat_d;
  logic [VW-1:0]    vic_way_q, vic_way_d;
  logic [IDXW-1:0]  line_idx_q, line_idx_d;
  logic [TAGW-1:0]  line_tag_q, line_tag_d;
  logic             from_flush_q, from_flush_d;
  logic             victim_full_q, victim_full_d;
  logic [IDXW-1:0]  scan_set_q, scan_set_d;
  logic [VW-1:0]    scan_way_q, scan_way_d;
  logic [VW-1:0]    vptr_q [SETS];

  logic [TAGW-1:0]  req_tag;
  logic [IDXW-1:0]  req_idx;
  logic [WBITS-1:0] req_word;
  logic             access;
  logic             unused_addr_lsb;

  logic [IDXW-1:0]  rd_idx;
  logic [WBITS-1:0] rd_word;
  logic             rd_valid [WAYS];
  logic             rd_dirty [WAYS];
  logic [TAGW-1:0]  rd_tag   [WAYS];
  logic [31:0]      rd_data  [WAYS];

  logic [WAYS-1:0]  wr_en, clean_en, fill_en;
  logic [IDXW-1:0]  wr_idx;
  logic [WBITS-1:0] wr_word;
  logic [31:0]      wr_data;
  logic             set_dirty;
  logic             vptr_adv;
  logic [VW-1:0]    vptr_nxt;

  logic             hit_any, free_any, last_beat, last_line;
  logic [VW-1:0]    hit_way, free_way, vic;

  assign req_tag         = TAGW'(Addr >> (OFF + IDXW + 2));
  assign req_idx         = IDXW'(Addr >> (OFF + 2));
  assign req_word        = (OFF == 0) ? '0 : WBITS'(Addr >> 2);
  assign access          = MemRead | MemWrite;
  assign unused_addr_lsb = ^Addr[1:0];

  assign last_beat = (beat_q == WBITS'(WORDS_PER_LINE - 1));
  assign last_line = (scan_set_q == IDXW'(SETS - 1)) && (scan_way_q == VW'(WAYS - 1));
  assign vptr_nxt  = (WAYS == 1) ? '0 : vptr_q[line_idx_q] + 1'b1;

  // Single shared read port: the core lookup in IDLE, the latched/scanned line otherwise.
  always_comb begin
    rd_idx  = line_idx_q;
    rd_word = beat_q;
    if (state_q == IDLE) begin
      rd_idx  = req_idx;
      rd_word = req_word;
    end else if (state_q == FLUSH) begin
      rd_idx  = scan_set_q;
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    dcache_way_array #(
      .SETS          (SETS),
      .WORDS_PER_LINE(WORDS_PER_LINE),
      .IDXW          (IDXW),
      .WBITS         (WBITS),
      .TAGW          (TAGW)
    ) u_way (
      .clk      (CLK),
      .rst      (Reset),
      .rd_idx   (rd_idx),
      .rd_word  (rd_word),
      .rd_valid (rd_valid[g]),
      .rd_dirty (rd_dirty[g]),
      .rd_tag   (rd_tag[g]),
      .rd_data  (rd_data[g]),
      .wr_en    (wr_en[g]),
      .wr_idx   (wr_idx),
      .wr_word  (wr_word),
      .wr_data  (wr_data),
      .set_dirty(set_dirty),
      .clean_en (clean_en[g]),
      .fill_en  (fill_en[g]),
      .fill_tag (line_tag_q)
    );
  end

  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    free_any = 1'b0;
    free_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit_any && rd_valid[w] && (rd_tag[w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = VW'(w);
      end
      if (!free_any && !rd_valid[w]) begin
        free_any = 1'b1;
        free_way = VW'(w);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    vic_way_d     = vic_way_q;
    line_idx_d    = line_idx_q;
    line_tag_d    = line_tag_q;
    from_flush_d  = from_flush_q;
    victim_full_d = victim_full_q;
    scan_set_d    = scan_set_q;
    scan_way_d    = scan_way_q;
    vic           = free_any ? free_way : vptr_q[req_idx];
    Hit           = 1'b0;
    Data          = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    wr_en         = '0;
    clean_en      = '0;
    fill_en       = '0;
    wr_idx        = line_idx_q;
    wr_word       = beat_q;
    wr_data       = mem_rdata;
    set_dirty     = 1'b0;
    vptr_adv      = 1'b0;

    case (state_q)
      IDLE: begin
        Hit = !access || hit_any;
        if (hit_any) Data = rd_data[hit_way];
        if (access && !hit_any) begin
          vic_way_d     = vic;
          line_idx_d    = req_idx;
          line_tag_d    = req_tag;
          beat_d        = '0;
          from_flush_d  = 1'b0;
          victim_full_d = !free_any;
          state_d       = (rd_valid[vic] && rd_dirty[vic]) ? WB : REFILL;
        end else if (MemWrite) begin
          wr_en[hit_way] = 1'b1;
          set_dirty      = 1'b1;
          wr_idx         = req_idx;
          wr_word        = req_word;
          wr_data        = WriteData;
        end else if (!access && Flush) begin
          scan_set_d = '0;
          scan_way_d = '0;
          state_d    = FLUSH;
        end
      end

      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_WIDTH'(line_beat_addr(64'(rd_tag[vic_way_q]), 64'(line_idx_q),
                                               64'(beat_q), OFF, IDXW));
        mem_wdata = rd_data[vic_way_q];
        if (mem_ready) begin
          if (last_beat) begin
            clean_en[vic_way_q] = 1'b1;
            beat_d              = '0;
            state_d             = from_flush_q ? FLUSH : REFILL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_WIDTH'(line_beat_addr(64'(line_tag_q), 64'(line_idx_q),
                                              64'(beat_q), OFF, IDXW));
        if (mem_ready) begin
          wr_en[vic_way_q] = 1'b1;
          if (last_beat) begin
            fill_en[vic_way_q] = 1'b1;
            vptr_adv           = victim_full_q;
            beat_d             = '0;
            state_d            = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      FLUSH: begin
        // A written-back line returns here still at the same position; it is clean then and the scan moves on.
        if (rd_valid[scan_way_q] && rd_dirty[scan_way_q]) begin
          vic_way_d    = scan_way_q;
          line_idx_d   = scan_set_q;
          beat_d       = '0;
          from_flush_d = 1'b1;
          state_d      = WB;
        end else if (last_line) begin
          state_d = IDLE;
        end else if (scan_way_q == VW'(WAYS - 1)) begin
          scan_way_d = '0;
          scan_set_d = scan_set_q + 1'b1;
        end else begin
          scan_way_d = scan_way_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (Reset) begin
      Hit     = 1'b1;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
    Busy = !Reset && (state_q != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      vic_way_q     <= '0;
      line_idx_q    <= '0;
      line_tag_q    <= '0;
      from_flush_q  <= 1'b0;
      victim_full_q <= 1'b0;
      scan_set_q    <= '0;
      scan_way_q    <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      vic_way_q     <= vic_way_d;
      line_idx_q    <= line_idx_d;
      line_tag_q    <= line_tag_d;
      from_flush_q  <= from_flush_d;
      victim_full_q <= victim_full_d;
      scan_set_q    <= scan_set_d;
      scan_way_q    <= scan_way_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int unsigned s = 0; s < SETS; s++) vptr_q[s] <= '0;
    end else if (vptr_adv) begin
      vptr_q[line_idx_q] <= vptr_nxt;
    end
  end

endmodule

// File: tb/tb_dcache_sa_wb.sv
// Directed bench for dcache_sa_wb: refill, store hit, dirty eviction, ready stalls, flush, reset mid-burst.
module tb_dcache_sa_wb;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] Addr;
  logic        MemRead, MemWrite, Flush;
  logic [31:0] WriteData;
  logic        Hit, Busy, mem_req, mem_we, mem_ready;
  logic [31:0] Data, mem_addr, mem_wdata, mem_rdata;

  int          checks = 0;
  int          failures = 0;
  int          cyc;
  int          base;
  logic [31:0] dout;

  logic [31:0] mem     [1024];
  bit          written [1024];
  beat_t       log_q[$];

  always #5 CLK = ~CLK;

  dcache_sa_wb #(
    .SETS(16), .WAYS(2), .WORDS_PER_LINE(4), .ADDR_WIDTH(32)
  ) dut (
    .CLK(CLK), .Reset(Reset), .Addr(Addr), .MemRead(MemRead), .MemWrite(MemWrite),
    .WriteData(WriteData), .Flush(Flush), .Hit(Hit), .Data(Data), .Busy(Busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Untouched memory word at byte address a reads as 0xA0000000 | a.
  assign mem_rdata = written[mem_addr[11:2]] ? mem[mem_addr[11:2]]
                                             : (32'hA000_0000 | {20'h0, mem_addr[11:0]});

  always @(posedge CLK) begin
    if (mem_req && mem_ready) begin
      log_q.push_back({mem_we, mem_addr, mem_wdata});
      if (mem_we) begin
        mem[mem_addr[11:2]]     = mem_wdata;
        written[mem_addr[11:2]] = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int k, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    b = '1;
    if (k < log_q.size()) b = log_q[k];
    chk(tag, b, {we, a, d});
  endtask

  task automatic do_reset();
    Reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Flush = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    Reset = 1'b0;
  endtask

  // Presents one access from cycle 1 until Hit; cyc is the cycle on which Hit was seen (0 = timeout).
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output int c, output logic [31:0] dv);
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd;
    c = 0; dv = '0;
    #1;
    for (int n = 1; n <= 200; n++) begin
      if (Hit) begin
        c  = n;
        dv = Data;
        break;
      end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic flush_and_wait(input string tag);
    int n;
    Flush = 1'b1;
    #1;
    @(posedge CLK); #1;
    Flush = 1'b0;
    chk({tag, "_busy"}, Busy, 1'b1);
    n = 0;
    while (Busy && n < 1000) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({tag, "_done"}, Busy, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Flush = 1'b0;
    Addr = '0; WriteData = '0; mem_ready = 1'b1;

    // Reset state
    @(posedge CLK); #1;
    chk("reset_during", {mem_req, mem_we, Busy, Hit}, 4'b0001);
    do_reset();
    #1;
    chk("reset_after", {mem_req, mem_we, Busy, Hit}, 4'b0001);
    @(posedge CLK); #1;

    // Clean miss on 0x100
    base = log_q.size();
    access(1'b1, 1'b0, 32'h100, 32'h0, cyc, dout);
    chk("load100_cycles", cyc, 6);
    chk("load100_data", dout, 32'hA000_0100);
    chk("load100_nbeats", log_q.size() - base, 4);
    for (int i = 0; i < 4; i++)
      chk_beat("load100_beat", base + i, 1'b0, 32'h100 + 32'(i * 4), 32'h0);

    // Store hit, then load back
    base = log_q.size();
    access(1'b0, 1'b1, 32'h104, 32'hDEADBEEF, cyc, dout);
    chk("store104_cycles", cyc, 1);
    access(1'b1, 1'b0, 32'h104, 32'h0, cyc, dout);
    chk("load104_cycles", cyc, 1);
    chk("load104_data", dout, 32'hDEADBEEF);
    chk("store_no_mem", log_q.size() - base, 0);

    // Dirty eviction from a full set, then victim pointer
    do_reset();
    access(1'b1, 1'b0, 32'h000, 32'h0, cyc, dout);
    access(1'b1, 1'b0, 32'h400, 32'h0, cyc, dout);
    chk("load400_cycles", cyc, 6);
    access(1'b0, 1'b1, 32'h008, 32'h1111_1111, cyc, dout);
    chk("store008_cycles", cyc, 1);
    base = log_q.size();
    access(1'b1, 1'b0, 32'h800, 32'h0, cyc, dout);
    chk("load800_cycles", cyc, 10);
    chk("load800_data", dout, 32'hA000_0800);
    chk("load800_nbeats", log_q.size() - base, 8);
    chk_beat("wb_beat0", base + 0, 1'b1, 32'h000, 32'hA000_0000);
    chk_beat("wb_beat1", base + 1, 1'b1, 32'h004, 32'hA000_0004);
    chk_beat("wb_beat2", base + 2, 1'b1, 32'h008, 32'h1111_1111);
    chk_beat("wb_beat3", base + 3, 1'b1, 32'h00C, 32'hA000_000C);
    for (int i = 0; i < 4; i++)
      chk_beat("rf800_beat", base + 4 + i, 1'b0, 32'h800 + 32'(i * 4), 32'h0);
    base = log_q.size();
    access(1'b1, 1'b0, 32'hC00, 32'h0, cyc, dout);
    chk("loadC00_clean_evict", log_q.size() - base, 4);
    access(1'b1, 1'b0, 32'h800, 32'h0, cyc, dout);
    chk("vptr_kept_800", cyc, 1);
    access(1'b1, 1'b0, 32'h400, 32'h0, cyc, dout);
    chk("vptr_evicted_400", cyc, 6);

    // mem_ready low for 3 cycles on refill beat 2
    do_reset();
    base = log_q.size();
    MemRead = 1'b1; Addr = 32'h100;
    #1;
    chk("stall_c1_hit", Hit, 1'b0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_hold", {mem_req, mem_we, mem_addr}, {2'b10, 32'h108});
      @(posedge CLK); #1;
    end
    mem_ready = 1'b1;
    #1;
    chk("stall_resume", {mem_req, mem_addr}, {1'b1, 32'h108});
    @(posedge CLK); #1;
    chk("stall_beat3", {mem_req, mem_addr}, {1'b1, 32'h10C});
    @(posedge CLK); #1;
    chk("stall_done", {Hit, Data}, {1'b1, 32'hA000_0100});
    @(posedge CLK); #1;
    MemRead = 1'b0;
    chk("stall_nbeats", log_q.size() - base, 4);
    chk_beat("stall_log2", base + 2, 1'b0, 32'h108, 32'h0);

    // Flush of two dirty lines
    do_reset();
    access(1'b1, 1'b0, 32'h030, 32'h0, cyc, dout);
    access(1'b0, 1'b1, 32'h434, 32'h2222_2222, cyc, dout);
    chk("store434_cycles", cyc, 6);
    access(1'b0, 1'b1, 32'h09C, 32'h5555_5555, cyc, dout);
    @(posedge CLK); #1;
    base = log_q.size();
    flush_and_wait("flush1");
    chk("flush_nbeats", log_q.size() - base, 8);
    chk_beat("fl_b0", base + 0, 1'b1, 32'h430, 32'hA000_0430);
    chk_beat("fl_b1", base + 1, 1'b1, 32'h434, 32'h2222_2222);
    chk_beat("fl_b2", base + 2, 1'b1, 32'h438, 32'hA000_0438);
    chk_beat("fl_b3", base + 3, 1'b1, 32'h43C, 32'hA000_043C);
    chk_beat("fl_b4", base + 4, 1'b1, 32'h090, 32'hA000_0090);
    chk_beat("fl_b5", base + 5, 1'b1, 32'h094, 32'hA000_0094);
    chk_beat("fl_b6", base + 6, 1'b1, 32'h098, 32'hA000_0098);
    chk_beat("fl_b7", base + 7, 1'b1, 32'h09C, 32'h5555_5555);
    base = log_q.size();
    access(1'b1, 1'b0, 32'h434, 32'h0, cyc, dout);
    chk("postflush_434", {cyc[7:0], dout}, {8'd1, 32'h2222_2222});
    access(1'b1, 1'b0, 32'h09C, 32'h0, cyc, dout);
    chk("postflush_09C", {cyc[7:0], dout}, {8'd1, 32'h5555_5555});
    access(1'b1, 1'b0, 32'h030, 32'h0, cyc, dout);
    chk("postflush_030", cyc, 1);
    flush_and_wait("flush2");
    chk("flush2_clean", log_q.size() - base, 0);

    // Reset during write-back beat 1
    do_reset();
    access(1'b1, 1'b0, 32'h000, 32'h0, cyc, dout);
    access(1'b0, 1'b1, 32'h000, 32'h3333_3333, cyc, dout);
    access(1'b1, 1'b0, 32'h400, 32'h0, cyc, dout);
    base = log_q.size();
    MemRead = 1'b1; Addr = 32'h800;
    #1;
    chk("rstwb_c1_hit", Hit, 1'b0);
    @(posedge CLK); #1;
    chk("rstwb_beat0", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h000, 32'h3333_3333});
    @(posedge CLK); #1;
    chk("rstwb_beat1", {mem_req, mem_we, mem_addr}, {2'b11, 32'h004});
    Reset = 1'b1; MemRead = 1'b0;
    #1;
    chk("rstwb_during", {mem_req, mem_we, Busy, Hit}, 4'b0001);
    @(posedge CLK); #1;
    Reset = 1'b0;
    #1;
    chk("rstwb_after", {mem_req, mem_we, Busy, Hit}, 4'b0001);
    chk("rstwb_nbeats", log_q.size() - base, 1);
    @(posedge CLK); #1;
    access(1'b1, 1'b0, 32'h000, 32'h0, cyc, dout);
    chk("rstwb_reload_cycles", cyc, 6);
    chk("rstwb_reload_data", dout, 32'h3333_3333);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_sa_wb.md
Name: dcache_sa_wb

Overview:
Parametrised set-associative, write-back, write-allocate data cache for the M stage of the five-stage pipelined core. It replaces the single-word-line cache. It adds configurable associativity, multi-word lines with burst refill and write-back, round-robin replacement and a full flush walk. Core side: combinational lookup, Hit low stalls E/M/W and F/D. Memory side: one word per beat over a req/ready handshake.

Parameters:
SETS, 16, number of sets; power of two, 2 or more.
WAYS, 2, associativity; power of two, 1 to 8.
WORDS_PER_LINE, 4, 32-bit words per line; power of two, 1 to 16.
ADDR_WIDTH, 32, byte address width; words are fixed at 32 bits.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
Reset  in  1  synchronous, active-high reset.
Addr  in  ADDR_WIDTH  byte address from the M stage (ALUResultM); bits [1:0] are ignored.
MemRead  in  1  load access.
MemWrite  in  1  store access.
WriteData  in  32  store data (after M-stage forwarding).
Flush  in  1  request write-back of all dirty lines; sampled only in IDLE with no access present.
Hit  out  1  high means the access completes this cycle and there is no stall; low means the pipeline must stall.
Data  out  32  load data; valid when Hit and MemRead are both high.
Busy  out  1  FSM not in IDLE.
mem_req  out  1  memory beat request.
mem_we  out  1  1 = write beat, 0 = read beat.
mem_addr  out  ADDR_WIDTH  word-aligned beat address.
mem_wdata  out  32  write-beat data.
mem_rdata  in  32  read-beat data; valid when mem_ready is high.
mem_ready  in  1  beat accepted or complete this cycle.

Behaviour:
- Address split: OFF = log2(WORDS_PER_LINE), IDX = log2(SETS). The word select is Addr[OFF+1:2], the set index is Addr[OFF+IDX+1:OFF+2], and the tag is the remaining upper bits.
- Per set and way: a valid bit, a dirty bit, the tag and the line data. Per set: a victim pointer of log2(WAYS) bits (a single-way cache needs no pointer).
- Reset: all valid and dirty bits cleared; victim pointers set to 0; state IDLE; beat counter and flush counters set to 0. During and after reset: mem_req=0, mem_we=0, Busy=0, Hit=1. Reset mid-burst abandons the burst with no line update.
- IDLE, combinational:
  - hit_way = the valid way with a matching tag.
  - Hit = 1 when neither MemRead nor MemWrite is asserted, or when a hit_way exists; otherwise 0.
  - Data = word[word select] of hit_way; 0 on a miss.
  - MemRead and MemWrite together are treated as a write.
- IDLE write hit: on the clock edge, the word is written and the line's dirty bit is set. Hit=1 in the same cycle, so there is no stall.
- IDLE miss: victim = the lowest-index invalid way if one exists, otherwise the set's victim pointer. The victim way and the line address are latched. Next state is WB if the victim is valid and dirty, otherwise REFILL.
- WB: beat i (from 0 to WORDS_PER_LINE-1) drives mem_req=1, mem_we=1, mem_addr = {victim tag, index, i, 2'b00} and mem_wdata = victim word i. The beat holds until mem_ready is high, then i increments. After the last beat, the line's dirty bit is cleared and the next state is REFILL (or FLUSH if this write-back came from a flush).
- REFILL: beat i drives mem_req=1, mem_we=0, mem_addr = {request tag, index, i, 2'b00}. On mem_ready, mem_rdata is written to word i. After the last beat: valid=1, the new tag is stored, dirty=0, the victim pointer advances by 1 (mod WAYS) if a full set forced the eviction, and the next state is IDLE.
- After return to IDLE: the stalled request is still presented, so it hits on the first IDLE cycle. Minimum clean-miss stall with mem_ready tied high = WORDS_PER_LINE+1 cycles. A dirty miss adds WORDS_PER_LINE cycles.
- Hit is 0 in every non-IDLE state.
- mem_req and the beat address and data are stable while waiting for mem_ready. mem_ready is ignored when mem_req=0.
- FLUSH: entered from IDLE when Flush=1 and there is no access. Scans set 0 to SETS-1 and way 0 to WAYS-1 at one line per cycle.
  - A dirty line triggers WB for that line, after which the scan resumes at the next line. Lines stay valid.
  - After the last line, the next state is IDLE.
  - A Flush pulse while Busy is dropped.
- Counters wrap only through explicit reset to 0 at burst or scan start. There is no partial-line state visible to the core.

Decomposition:
- Package dcache_pkg: state enum (IDLE, WB, REFILL, FLUSH), plus localparam functions for OFF, IDX and TAG widths, and the address-composition helper.
- One natural sub-module: dcache_way_array. It holds one way's tag, valid, dirty and data storage with read ports for index and word and a write port. It is instantiated WAYS times via generate.

Test Plan:
- Reset, then a load from 0x100 (default parameters) with mem_ready held high. Required: Hit=0; 4 read beats at 0x100, 0x104, 0x108, 0x10C; Hit=1 on cycle 6; Data = mem word 0x100.
- Store 0xDEADBEEF to 0x104 after the line is resident. Required: Hit=1 with no stall; a following load from 0x104 returns 0xDEADBEEF; no mem_req.
- Fill both ways of set 0 (0x000, 0x400), dirty 0x000, then load 0x800. Required: write beats at 0x000 to 0x00C carrying the dirty data, then read beats at 0x800 to 0x80C; the victim pointer becomes 1.
- mem_ready low for 3 cycles during REFILL beat 2. Required: mem_addr held at 0x108 with mem_req=1; no beat advance; completes after mem_ready rises.
- Two dirty lines (set 3 way 1, set 9 way 0), then Flush. Required: exactly 8 write beats in set/way order; Busy low afterwards; lines still hit with dirty=0.
- Reset asserted during WB beat 1. Required: the next cycle has mem_req=0, Busy=0, Hit=1, and the earlier line misses.
